note_tone_gen: RTL and testbench

//  Downstream stage of the melody FSMs: consumes the 5-bit note index they emit
//  (0..24 = semitones C4..C6, 25..31 = rest) and drives a 1-bit square wave to the speaker pin.

---
 rtl/note_tone_gen_if.sv | 31 +++
 rtl/note_tone_gen.sv | 181 ++++++++++++++++++
 tb/tb_note_tone_gen.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_tone_gen_if.sv
// -----------------------------------------------------------------------------
// note_tone_gen_if
//   Bundles the note input and tone/status outputs of note_tone_gen.
//   master : melody side (drives note_in/enable, observes status)
//   slave  : note_tone_gen side
// Signals:
//   note_in     [4:0]  note index (0..24 = C4..C6, 25..31 = rest)
//   enable             1 = play, 0 = mute
//   spk                speaker drive
//   active_note [4:0]  note currently being played
//   note_change        one-cycle pulse when active_note updates
//   amp         [7:0]  current envelope amplitude
// -----------------------------------------------------------------------------
interface note_tone_gen_if;
   logic [4:0] note_in;
   logic       enable;
   logic       spk;
   logic [4:0] active_note;
   logic       note_change;
   logic [7:0] amp;

   modport master (
      output note_in, enable,
      input  spk, active_note, note_change, amp
   );

   modport slave (
      input  note_in, enable,
      output spk, active_note, note_change, amp
   );
endinterface

// File: rtl/note_tone_gen.sv
// -----------------------------------------------------------------------------
// note_tone_gen
//   Turns the 5-bit note index from the melody FSMs into a square wave on the
//   speaker pin. Note changes restart the tone divider and raise a one-cycle
//   note_change pulse for the display logic.
//
//   Optional feature macro: ENVELOPE_EN
//     defined   : plucked decay envelope, applied to spk through 8-bit PWM
//     undefined : amp tied to 8'hFF, spk is the registered square wave
//
// Parameters:
//   OCT_SHIFT  right shift of the half-period table (0..2, 1 = octave up)
//   DECAY_DIV  clocks per envelope decrement (ENVELOPE_EN only)
//   MIN_AMP    envelope floor, 0..255 (ENVELOPE_EN only)
// Ports:
//   clk    50 MHz system clock
//   rst_n  asynchronous active-low reset
//   bus    note_tone_gen_if.slave (note_in, enable, spk, active_note,
//          note_change, amp)
// -----------------------------------------------------------------------------
module note_tone_gen #(
   parameter int unsigned OCT_SHIFT = 0,
   parameter int unsigned DECAY_DIV = 250000,
   parameter int unsigned MIN_AMP   = 32
) (
   input logic            clk,
   input logic            rst_n,
   note_tone_gen_if.slave bus
);

   localparam logic [4:0] REST_NOTE = 5'd25;

   // Reject configurations the hardware cannot represent.
   if (OCT_SHIFT > 2 || MIN_AMP > 255 || DECAY_DIV < 1 || DECAY_DIV > 262144)
   begin : g_bad_cfg
      $error("note_tone_gen: illegal OCT_SHIFT/DECAY_DIV/MIN_AMP");
   end

   // Half period in clocks, round(25e6 / f(n)), for C4..C6.
   // NOTE: this is a constant ROM decoded from the index; it holds no state,
   // so there is nothing to reset.
   function automatic logic [16:0] hp_base(input logic [4:0] n);
      case (n)
         5'd0:  hp_base = 17'd95556;
         5'd1:  hp_base = 17'd90193;
         5'd2:  hp_base = 17'd85131;
         5'd3:  hp_base = 17'd80353;
         5'd4:  hp_base = 17'd75843;
         5'd5:  hp_base = 17'd71586;
         5'd6:  hp_base = 17'd67569;
         5'd7:  hp_base = 17'd63776;
         5'd8:  hp_base = 17'd60197;
         5'd9:  hp_base = 17'd56818;
         5'd10: hp_base = 17'd53629;
         5'd11: hp_base = 17'd50619;
         5'd12: hp_base = 17'd47778;
         5'd13: hp_base = 17'd45097;
         5'd14: hp_base = 17'd42566;
         5'd15: hp_base = 17'd40177;
         5'd16: hp_base = 17'd37922;
         5'd17: hp_base = 17'd35793;
         5'd18: hp_base = 17'd33784;
         5'd19: hp_base = 17'd31888;
         5'd20: hp_base = 17'd30098;
         5'd21: hp_base = 17'd28409;
         5'd22: hp_base = 17'd26815;
         5'd23: hp_base = 17'd25310;
         5'd24: hp_base = 17'd23889;
         default: hp_base = 17'd0;
      endcase
   endfunction

   logic [4:0]  note_q;
   logic [4:0]  active_note;
   logic        note_change;
   logic [16:0] cnt;
   logic        sq;
   logic        spk;
   logic        change;
   logic        is_tone;
   logic        playing;
   logic [16:0] hp;

   assign change  = (note_q != active_note);
   assign is_tone = (active_note < REST_NOTE);
   assign playing = is_tone & bus.enable;
   assign hp      = hp_base(active_note) >> OCT_SHIFT;

   // Input register and change detection: note_in reaches active_note two
   // clocks later, and every distinct value seen in note_q gets its own pulse.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_q      <= REST_NOTE;
         active_note <= REST_NOTE;
         note_change <= 1'b0;
      end else begin
         note_q <= bus.note_in;
         if (change) begin
            active_note <= note_q;
            note_change <= 1'b1;
         end else begin
            note_change <= 1'b0;
         end
      end
   end

   // Tone divider. A note change restarts the count but keeps the square
   // wave level, so the first toggle of the new note lands HP(new) clocks
   // after active_note updates. Rest or mute parks the wave low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sq  <= 1'b0;
      end else if (change) begin
         cnt <= '0;
      end else if (!playing) begin
         cnt <= '0;
         sq  <= 1'b0;
      end else if (cnt == hp - 17'd1) begin
         cnt <= '0;
         sq  <= ~sq;
      end else begin
         cnt <= cnt + 17'd1;
      end
   end

`ifdef ENVELOPE_EN
   localparam logic [17:0] DECAY_LAST = 18'(DECAY_DIV - 1);
   localparam logic [7:0]  AMP_FLOOR  = 8'(MIN_AMP);

   logic [7:0]  pwm_cnt;
   logic [17:0] dcnt;
   logic [7:0]  amp;

   // Envelope: full scale on each new tone, then one step down every
   // DECAY_DIV clocks until the floor is reached. Rests silence it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         dcnt    <= '0;
         amp     <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (change && (note_q < REST_NOTE)) begin
            amp  <= 8'hFF;
            dcnt <= '0;
         end else if (!is_tone) begin
            amp  <= '0;
            dcnt <= '0;
         end else if (dcnt == DECAY_LAST) begin
            dcnt <= '0;
            if (amp > AMP_FLOOR) amp <= amp - 8'd1;
         end else begin
            dcnt <= dcnt + 18'd1;
         end
      end
   end

   // PWM gate: spk is high for amp out of every 256 clocks while sq is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) spk <= 1'b0;
      else        spk <= sq & (pwm_cnt < amp);
   end

   assign bus.amp = amp;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) spk <= 1'b0;
      else        spk <= sq;
   end

   assign bus.amp = 8'hFF;
`endif

   assign bus.spk         = spk;
   assign bus.active_note = active_note;
   assign bus.note_change = note_change;

endmodule

// File: tb/tb_note_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_note_tone_gen
//   Directed bench for note_tone_gen. A second instance with OCT_SHIFT=1
//   plays note 12 from reset and is watched by a background monitor.
//   Timing figures count clocks between samples taken 1 time unit after the
//   rising edge; spk lags the internal square wave by one clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_note_tone_gen;

   localparam int HP0  = 95556;
   localparam int HP12 = 47778;
   localparam int HP24 = 23889;

`ifdef ENVELOPE_EN
   localparam logic [7:0] RST_AMP  = 8'h00;
   localparam logic [7:0] REST_AMP = 8'h00;
`else
   localparam logic [7:0] RST_AMP  = 8'hFF;
   localparam logic [7:0] REST_AMP = 8'hFF;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int asserts = 0;
   int fails   = 0;

   note_tone_gen_if bus ();
   note_tone_gen_if bus2 ();

   note_tone_gen #(.OCT_SHIFT(0), .DECAY_DIV(4), .MIN_AMP(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   note_tone_gen #(.OCT_SHIFT(1), .DECAY_DIV(4), .MIN_AMP(32)) dut_oct (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   // Background monitor on the OCT_SHIFT=1 instance.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned t_upd      = 0;
   bit          upd_seen   = 1'b0;
   int unsigned t_edge [4] = '{default: 0};
   int          n_edge     = 0;
   logic        spk2_prev  = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         upd_seen  <= 1'b0;
         n_edge    <= 0;
         spk2_prev <= 1'b0;
      end else begin
         if (!upd_seen && bus2.active_note == 5'd12) begin
            upd_seen <= 1'b1;
            t_upd    <= cyc;
         end
         if (bus2.spk !== spk2_prev && n_edge < 4) begin
            t_edge[n_edge] <= cyc;
            n_edge         <= n_edge + 1;
         end
         spk2_prev <= bus2.spk;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Ticks until spk equals lvl; n is the tick count, limit+1 on timeout.
   task automatic wait_spk(input logic lvl, input int limit, output int n);
      n = 0;
      while (bus.spk !== lvl && n <= limit) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 4; i++) begin
         tick();
         asserts++;
         if (bus.spk !== 1'b0 || bus.active_note !== 5'd25 ||
             bus.note_change !== 1'b0 || bus.amp !== RST_AMP) begin
            fails++;
            $display("FAIL reset_state: spk=%b active_note=%0d note_change=%b amp=%0d, expected 0/25/0/%0d",
                     bus.spk, bus.active_note, bus.note_change, bus.amp, RST_AMP);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_latency;
      bit bad;
      tick();
      asserts++;
      if (bus.active_note !== 5'd25 || bus.note_change !== 1'b0) begin
         fails++;
         $display("FAIL latency_1clk: active_note=%0d note_change=%b, expected 25/0",
                  bus.active_note, bus.note_change);
      end
      tick();
      asserts++;
      if (bus.active_note !== 5'd12 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL latency_2clk: active_note=%0d note_change=%b, expected 12/1",
                  bus.active_note, bus.note_change);
      end
      bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (bus.note_change !== 1'b0 || bus.active_note !== 5'd12) bad = 1'b1;
      end
      asserts++;
      if (bad) begin
         fails++;
         $display("FAIL held_note_pulse: extra note_change or active_note drift, expected none");
      end
   endtask

   task automatic test_note_switch;
      int n;
      int pulses;
      bus.note_in = 5'd0;
      tick(2);
      asserts++;
      if (bus.active_note !== 5'd0 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL switch_to_0: active_note=%0d note_change=%b, expected 0/1",
                  bus.active_note, bus.note_change);
      end
      tick(500);
      bus.note_in = 5'd24;
      tick(2);
      asserts++;
      if (bus.active_note !== 5'd24 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL switch_to_24: active_note=%0d note_change=%b, expected 24/1",
                  bus.active_note, bus.note_change);
      end
      n = 0;
      pulses = 0;
      while (bus.spk !== 1'b1 && n <= 30000) begin
         tick();
         n++;
         if (bus.note_change === 1'b1) pulses++;
      end
      asserts++;
      if (n !== HP24 + 1) begin
         fails++;
         $display("FAIL first_toggle_24: spk rose after %0d clks, expected %0d", n, HP24 + 1);
      end
      asserts++;
      if (pulses !== 0) begin
         fails++;
         $display("FAIL single_pulse_24: %0d extra pulses, expected 0", pulses);
      end
   endtask

   task automatic test_enable;
      int  n;
      bit  bad;
      tick(100);
      asserts++;
      if (bus.spk !== 1'b1) begin
         fails++;
         $display("FAIL high_phase: spk=%b, expected 1", bus.spk);
      end
      bus.enable = 1'b0;
      tick(2);
      asserts++;
      if (bus.spk !== 1'b0) begin
         fails++;
         $display("FAIL mute_2clk: spk=%b, expected 0", bus.spk);
      end
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus.spk !== 1'b0) bad = 1'b1;
      end
      asserts++;
      if (bad) begin
         fails++;
         $display("FAIL mute_hold: spk toggled while muted, expected 0");
      end
      bus.enable = 1'b1;
      wait_spk(1'b1, 30000, n);
      asserts++;
      if (n !== HP24 + 1) begin
         fails++;
         $display("FAIL reenable_rise: spk rose after %0d clks, expected %0d", n, HP24 + 1);
      end
   endtask

   task automatic test_rest;
      bit bad;
      foreach (bus.note_in[i]) bus.note_in[i] = 1'b0;
      bus.note_in = 5'd25;
      tick(2);
      asserts++;
      if (bus.active_note !== 5'd25 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL rest_25: active_note=%0d note_change=%b, expected 25/1",
                  bus.active_note, bus.note_change);
      end
      tick(2);
      asserts++;
      if (bus.spk !== 1'b0 || bus.amp !== REST_AMP) begin
         fails++;
         $display("FAIL rest_silence: spk=%b amp=%0d, expected 0/%0d", bus.spk, bus.amp, REST_AMP);
      end
      bad = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (bus.spk !== 1'b0 || bus.note_change !== 1'b0) bad = 1'b1;
      end
      asserts++;
      if (bad) begin
         fails++;
         $display("FAIL rest_25_hold: spk or note_change active during rest, expected 0");
      end
      bus.note_in = 5'd31;
      tick(2);
      asserts++;
      if (bus.active_note !== 5'd31 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL rest_31: active_note=%0d note_change=%b, expected 31/1",
                  bus.active_note, bus.note_change);
      end
      bad = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (bus.spk !== 1'b0 || bus.note_change !== 1'b0) bad = 1'b1;
      end
      asserts++;
      if (bad) begin
         fails++;
         $display("FAIL rest_31_hold: spk or note_change active during rest, expected 0");
      end
   endtask

   task automatic test_back_to_back;
      bus.note_in = 5'd1;
      tick();
      bus.note_in = 5'd2;
      tick();
      asserts++;
      if (bus.active_note !== 5'd1 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL b2b_1: active_note=%0d note_change=%b, expected 1/1",
                  bus.active_note, bus.note_change);
      end
      bus.note_in = 5'd3;
      tick();
      asserts++;
      if (bus.active_note !== 5'd2 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL b2b_2: active_note=%0d note_change=%b, expected 2/1",
                  bus.active_note, bus.note_change);
      end
      tick();
      asserts++;
      if (bus.active_note !== 5'd3 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL b2b_3: active_note=%0d note_change=%b, expected 3/1",
                  bus.active_note, bus.note_change);
      end
      tick();
      asserts++;
      if (bus.note_change !== 1'b0) begin
         fails++;
         $display("FAIL b2b_end: note_change=%b, expected 0", bus.note_change);
      end
   endtask

`ifndef ENVELOPE_EN
   task automatic test_oct_shift;
      int guard;
      guard = 0;
      while (n_edge < 3 && guard < 40000) begin
         tick();
         guard++;
      end
      asserts++;
      if (n_edge < 3) begin
         fails++;
         $display("FAIL oct_edges: saw %0d spk edges, expected at least 3", n_edge);
      end else begin
         asserts++;
         if (t_edge[0] - t_upd !== HP0 / 4 + 1) begin
            fails++;
            $display("FAIL oct_first_rise: %0d clks after update, expected %0d",
                     t_edge[0] - t_upd, HP0 / 4 + 1);
         end
         asserts++;
         if (t_edge[1] - t_edge[0] !== HP12 / 2 || t_edge[2] - t_edge[1] !== HP12 / 2) begin
            fails++;
            $display("FAIL oct_duty: high=%0d low=%0d clks, expected %0d each",
                     t_edge[1] - t_edge[0], t_edge[2] - t_edge[1], HP12 / 2);
         end
         asserts++;
         if (t_edge[2] - t_edge[0] !== HP12) begin
            fails++;
            $display("FAIL oct_period: %0d clks, expected %0d", t_edge[2] - t_edge[0], HP12);
         end
      end
   endtask
`endif

`ifdef ENVELOPE_EN
   task automatic test_envelope;
      int n;
      int hi;
      bus.note_in = 5'd24;
      tick(2);
      asserts++;
      if (bus.active_note !== 5'd24 || bus.amp !== 8'd255) begin
         fails++;
         $display("FAIL env_load: active_note=%0d amp=%0d, expected 24/255", bus.active_note, bus.amp);
      end
      tick(40);
      asserts++;
      if (bus.amp !== 8'd245) begin
         fails++;
         $display("FAIL env_40clk: amp=%0d, expected 245", bus.amp);
      end
      tick(852);
      asserts++;
      if (bus.amp !== 8'd32) begin
         fails++;
         $display("FAIL env_floor: amp=%0d, expected 32", bus.amp);
      end
      tick(100);
      asserts++;
      if (bus.amp !== 8'd32) begin
         fails++;
         $display("FAIL env_floor_hold: amp=%0d, expected 32", bus.amp);
      end
      wait_spk(1'b1, 25000, n);
      asserts++;
      if (n > 25000) begin
         fails++;
         $display("FAIL env_spk_rise: no spk pulse within %0d clks, expected one", n);
      end
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         if (bus.spk === 1'b1) hi++;
         tick();
      end
      asserts++;
      if (hi !== 32) begin
         fails++;
         $display("FAIL env_pwm_duty: %0d high clks per 256, expected 32", hi);
      end
   endtask
`endif

   task automatic test_async_reset;
      bus.note_in = 5'd5;
      tick(2);
      asserts++;
      if (bus.active_note !== 5'd5 || bus.note_change !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset: active_note=%0d note_change=%b, expected 5/1",
                  bus.active_note, bus.note_change);
      end
      #2 rst_n = 1'b0;
      #1;
      asserts++;
      if (bus.active_note !== 5'd25 || bus.note_change !== 1'b0 ||
          bus.spk !== 1'b0 || bus.amp !== RST_AMP) begin
         fails++;
         $display("FAIL async_reset: active_note=%0d note_change=%b spk=%b amp=%0d, expected 25/0/0/%0d",
                  bus.active_note, bus.note_change, bus.spk, bus.amp, RST_AMP);
      end
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.note_in  = 5'd12;
      bus.enable   = 1'b1;
      bus2.note_in = 5'd12;
      bus2.enable  = 1'b1;
      test_reset();
      test_latency();
`ifdef ENVELOPE_EN
      test_envelope();
`else
      test_note_switch();
      test_enable();
`endif
      test_rest();
      test_back_to_back();
`ifndef ENVELOPE_EN
      test_oct_shift();
`endif
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
